mlp_seq_regressor: RTL

MLP_SEQ_REGRESSOR -- requirements
Module: mlp_seq_regressor

---
 rtl/mlp_seq_pkg.sv | 18 +
 rtl/mlp_mac.sv | 29 ++
 rtl/mlp_seq_regressor.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mlp_seq_pkg.sv
// rtl/mlp_seq_pkg.sv - FSM state type and trained weights/biases for mlp_seq_regressor
package mlp_seq_pkg;

  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

  localparam int PKG_N_IN  = 11;
  localparam int PKG_N_HID = 2;

  // W0[h][k] multiplies feature k into hidden neuron h
  localparam int W0 [PKG_N_HID][PKG_N_IN] = '{
    '{-23, 72, 16, -8, 40, -12, 34, 18, 12, -56, -88},
    '{ -4, -4, -4,  9,  0,  -8, -7, -8, -4,  -8,  -7}
  };
  localparam int W1 [PKG_N_HID] = '{-6, -4};
  localparam int B0 [PKG_N_HID] = '{688, 108};
  localparam int B1             = 27282;

endpackage

// File: rtl/mlp_mac.sv
// rtl/mlp_mac.sv - signed multiply-accumulate with bias load, wraps at ACC_W bits
module mlp_mac #(
  parameter int A_W   = 5,
  parameter int B_W   = 8,
  parameter int ACC_W = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] bias,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc_next
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;

  // product taken modulo 2^ACC_W, identical to truncating the full-width product
  assign prod     = ACC_W'(a) * ACC_W'(b);
  assign acc_next = (load ? bias : acc) + prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc_next;
  end

endmodule

// File: rtl/mlp_seq_regressor.sv
// rtl/mlp_seq_regressor.sv - sequential 1-MAC-per-cycle two-layer MLP regressor
// Optional MLP_SEQ_OUT_RELU_EN clamps the final result at zero.
module mlp_seq_regressor import mlp_seq_pkg::*; #(
  parameter int N_IN   = 11,
  parameter int IN_W   = 4,
  parameter int N_HID  = 2,
  parameter int W_W    = 8,
  parameter int ACC0_W = 13,
  parameter int ACC1_W = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*IN_W-1:0]   inp,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC1_W-1:0]      out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int K_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int H_W  = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int HA_W = ACC0_W - 1;

  state_t state, state_nxt;

  logic [N_IN*IN_W-1:0]    inp_q;
  logic [K_W-1:0]          cnt_k;
  logic [H_W-1:0]          cnt_h;
  logic [HA_W-1:0]         hid [N_HID];
  logic [IN_W-1:0]         feats [N_IN];
  logic                    last_k, last_h;
  logic                    hid_en, out_en, hid_store, res_load;
  logic signed [ACC0_W-1:0] hid_acc_next;
  logic signed [ACC1_W-1:0] out_acc_next;
  logic signed [ACC1_W-1:0] res;

  for (genvar g = 0; g < N_IN; g++) begin : g_feat
    assign feats[g] = inp_q[g*IN_W +: IN_W];
  end

  assign last_k = (cnt_k == K_W'(N_IN - 1));
  assign last_h = (cnt_h == H_W'(N_HID - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)         state_nxt = HID;
      HID:  if (last_k && last_h) state_nxt = OUT;
      OUT:  if (last_h)           state_nxt = DONE;
      DONE: if (out_ready)        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    hid_en    = 1'b0;
    out_en    = 1'b0;
    hid_store = 1'b0;
    res_load  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      HID: begin
        hid_en    = 1'b1;
        hid_store = last_k;
      end
      OUT: begin
        out_en   = 1'b1;
        res_load = last_h;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       inp_q <= '0;
    else if (in_valid && in_ready) inp_q <= inp;
  end

  // cnt_k walks features within a neuron; cnt_h walks neurons in both layers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_k <= '0;
      cnt_h <= '0;
    end else begin
      case (state)
        HID: begin
          if (last_k) begin
            cnt_k <= '0;
            cnt_h <= last_h ? '0 : cnt_h + H_W'(1);
          end else begin
            cnt_k <= cnt_k + K_W'(1);
          end
        end
        OUT: cnt_h <= last_h ? '0 : cnt_h + H_W'(1);
        default: begin
          cnt_k <= '0;
          cnt_h <= '0;
        end
      endcase
    end
  end

  mlp_mac #(.A_W(IN_W + 1), .B_W(W_W), .ACC_W(ACC0_W)) u_hid_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (hid_en),
    .load     (cnt_k == '0),
    .bias     (ACC0_W'(B0[cnt_h])),
    .a        ($signed({1'b0, feats[cnt_k]})),
    .b        (W_W'(W0[cnt_h][cnt_k])),
    .acc_next (hid_acc_next)
  );

  mlp_mac #(.A_W(ACC0_W), .B_W(W_W), .ACC_W(ACC1_W)) u_out_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (out_en),
    .load     (cnt_h == '0),
    .bias     (ACC1_W'(B1)),
    .a        ($signed({1'b0, hid[cnt_h]})),
    .b        (W_W'(W1[cnt_h])),
    .acc_next (out_acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            hid <= '{default: '0};
    else if (hid_store) hid[cnt_h] <= hid_acc_next[ACC0_W-1] ? '0 : hid_acc_next[HA_W-1:0];
  end

`ifdef MLP_SEQ_OUT_RELU_EN
  assign res = out_acc_next[ACC1_W-1] ? '0 : out_acc_next;
`else
  assign res = out_acc_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (res_load) begin
      out       <= res;
      out_valid <= 1'b1;
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
